// File: rtl/tc_fifo_arbiter.sv
// Round-robin scheduler that merges four per-class source FIFOs into one
// downstream FIFO. Each cycle at most one non-empty source is popped. Its word
// is captured one cycle later and pushed downstream two cycles after the pop.
module tc_fifo_arbiter #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned BURST   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_SRC-1:0]        src_empty,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [NUM_SRC-1:0]        src_pop,
    input  logic                      dst_almost_full,
    output logic                      dst_push,
    output logic [DATA_W-1:0]         dst_data,
    output logic [1:0]                grant_id,
    output logic                      grant_valid,
    output logic [NUM_SRC*8-1:0]      class_cnt
);

    // Stay on the last class while the burst count is below this value.
    localparam logic [3:0] BurstLim = 4'(BURST - 1);

    logic [1:0]         last_q;
    logic [3:0]         burst_q;
    logic               started_q;  // a real grant has happened since reset
    logic [NUM_SRC-1:0] elig;
    logic               can_issue;
    logic [1:0]         sel;
    logic [1:0]         idx;
    logic               found;
    logic [3:0]         burst_d;

    // Pick the next class and drive the pop in the same cycle.
    always_comb begin
        elig      = ~src_empty;
        can_issue = enable & ~dst_almost_full & ~reset & (elig != '0);
        sel       = last_q;
        burst_d   = burst_q;
        idx       = last_q;
        found     = 1'b0;
        if (started_q && elig[last_q] && (burst_q < BurstLim)) begin
            sel     = last_q;
            burst_d = burst_q + 4'd1;
        end else begin
            // Scan last+1 .. last+4; the final step wraps back onto last itself,
            // so a lone eligible class keeps its grant regardless of the burst.
            for (int unsigned k = 1; k <= NUM_SRC; k++) begin
                idx = last_q + 2'(k);
                if (!found && elig[idx]) begin
                    sel   = idx;
                    found = 1'b1;
                end
            end
            if (!started_q || (sel != last_q)) begin
                burst_d = 4'd0;
            end else if (burst_q != 4'hF) begin
                burst_d = burst_q + 4'd1;
            end
        end
        src_pop = '0;
        if (can_issue) begin
            src_pop[sel] = 1'b1;
        end
    end

    // Scheduler state: last granted class and its consecutive-grant count.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q    <= 2'd3;
            burst_q   <= 4'd0;
            started_q <= 1'b0;
        end else if (can_issue) begin
            last_q    <= sel;
            burst_q   <= burst_d;
            started_q <= 1'b1;
        end
    end

    // Two-stage pipeline: grant stage, then capture/push and per-class count.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_valid <= 1'b0;
            grant_id    <= 2'd0;
            dst_push    <= 1'b0;
            dst_data    <= '0;
            class_cnt   <= '0;
        end else begin
            grant_valid <= can_issue;
            if (can_issue) begin
                grant_id <= sel;
            end
            dst_push <= grant_valid;
            if (grant_valid) begin
                dst_data <= src_data[32'(grant_id)*DATA_W +: DATA_W];
                class_cnt[32'(grant_id)*8 +: 8] <= class_cnt[32'(grant_id)*8 +: 8] + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_tc_fifo_arbiter.sv
// Directed bench for tc_fifo_arbiter: models the four source FIFOs, logs
// pops, grants and pushes per cycle and checks them against hand-written tables.
module tb_tc_fifo_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        dst_almost_full = 1'b0;
    logic [3:0]  src_empty = 4'hF;
    logic [47:0] src_data = '0;
    logic [3:0]  src_pop;
    logic        dst_push;
    logic [11:0] dst_data;
    logic [1:0]  grant_id;
    logic        grant_valid;
    logic [31:0] class_cnt;

    tc_fifo_arbiter #(
        .NUM_SRC(4),
        .DATA_W (12),
        .BURST  (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .src_empty      (src_empty),
        .src_data       (src_data),
        .src_pop        (src_pop),
        .dst_almost_full(dst_almost_full),
        .dst_push       (dst_push),
        .dst_data       (dst_data),
        .grant_id       (grant_id),
        .grant_valid    (grant_valid),
        .class_cnt      (class_cnt)
    );

    logic [11:0] q0[$];
    logic [11:0] q1[$];
    logic [11:0] q2[$];
    logic [11:0] q3[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0;
    logic [3:0] pop_s;

    int          pop_c[$];
    logic [1:0]  pop_cls[$];
    int          push_c[$];
    logic [11:0] push_d[$];
    int          gnt_c[$];
    logic [1:0]  gnt_id[$];

    logic [1:0]  exp_ord2[16] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3,
                                  2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    logic [11:0] exp_dat2[16] = '{12'h500, 12'h501, 12'h510, 12'h511,
                                  12'h520, 12'h521, 12'h530, 12'h531,
                                  12'h502, 12'h503, 12'h512, 12'h513,
                                  12'h522, 12'h523, 12'h532, 12'h533};
    logic [1:0]  exp_ord4[8]  = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd1, 2'd1};
    logic [11:0] exp_dat4[8]  = '{12'h600, 12'h601, 12'h610, 12'h611,
                                  12'h602, 12'h603, 12'h612, 12'h613};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void refresh();
        src_empty = {q3.size() == 0, q2.size() == 0, q1.size() == 0, q0.size() == 0};
    endfunction

    function automatic int qsize(input int s);
        case (s)
            0:       return q0.size();
            1:       return q1.size();
            2:       return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic logic [11:0] qpop(input int s);
        case (s)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            2:       return q2.pop_front();
            default: return q3.pop_front();
        endcase
    endfunction

    task automatic load(input int s, input logic [11:0] w);
        case (s)
            0:       q0.push_back(w);
            1:       q1.push_back(w);
            2:       q2.push_back(w);
            default: q3.push_back(w);
        endcase
        refresh();
    endtask

    task automatic clear_logs();
        pop_c.delete();
        pop_cls.delete();
        push_c.delete();
        push_d.delete();
        gnt_c.delete();
        gnt_id.delete();
    endtask

    // One clock: sample at negedge, then update the source model just after posedge.
    task automatic step();
        int first;
        @(negedge clk);
        pop_s = src_pop;
        chk("pop_onehot", {31'd0, $onehot0(src_pop)}, 32'd1);
        if (src_pop != 4'd0) begin
            first = 0;
            for (int i = 3; i >= 0; i--) if (src_pop[i]) first = i;
            pop_c.push_back(cyc);
            pop_cls.push_back(2'(first));
        end
        if (dst_push) begin
            push_c.push_back(cyc);
            push_d.push_back(dst_data);
        end
        if (grant_valid) begin
            gnt_c.push_back(cyc);
            gnt_id.push_back(grant_id);
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (pop_s[i]) begin
                chk("pop_nonempty", {31'd0, qsize(i) != 0}, 32'd1);
                if (qsize(i) != 0) src_data[12*i +: 12] = qpop(i);
            end
        end
        refresh();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held two cycles with all sources loaded.
        for (int s = 0; s < 4; s++)
            for (int k = 0; k < 4; k++) load(s, 12'(12'h500 + 16 * s + k));
        repeat (2) step();
        #1;
        chk("rst_no_pop", 32'(pop_c.size()), 32'd0);
        chk("rst_pop_now", 32'(src_pop), 32'd0);
        chk("rst_push", 32'(dst_push), 32'd0);
        chk("rst_data", 32'(dst_data), 32'd0);
        chk("rst_gvalid", 32'(grant_valid), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        chk("rst_cnt", class_cnt, 32'd0);
        reset = 1'b0;
        clear_logs();

        // Fairness with burst 2.
        t0 = cyc;
        for (int c = 0; c < 40 && push_d.size() < 16; c++) step();
        repeat (3) step();
        chk("fair_npop", 32'(pop_c.size()), 32'd16);
        chk("fair_npush", 32'(push_d.size()), 32'd16);
        if (pop_c.size() == 16 && push_d.size() == 16 && gnt_id.size() == 16) begin
            chk("fair_first_cyc", 32'(pop_c[0]), 32'(t0));
            for (int k = 0; k < 16; k++) begin
                chk("fair_order", 32'(pop_cls[k]), 32'(exp_ord2[k]));
                chk("fair_data", 32'(push_d[k]), 32'(exp_dat2[k]));
                chk("fair_lat", 32'(push_c[k] - pop_c[k]), 32'd2);
                chk("fair_gid", 32'(gnt_id[k]), 32'(exp_ord2[k]));
                chk("fair_glat", 32'(gnt_c[k] - pop_c[k]), 32'd1);
                chk("fair_rate", 32'(pop_c[k] - pop_c[0]), 32'(k));
            end
        end
        chk("fair_cnt", class_cnt, 32'h04040404);

        // Lone source: class 2 keeps the grant with no burst break.
        clear_logs();
        for (int k = 0; k < 5; k++) load(2, 12'(12'h2A0 + k));
        for (int c = 0; c < 30 && push_d.size() < 5; c++) step();
        repeat (3) step();
        chk("lone_npop", 32'(pop_c.size()), 32'd5);
        chk("lone_npush", 32'(push_d.size()), 32'd5);
        if (pop_c.size() == 5 && push_d.size() == 5) begin
            for (int k = 0; k < 5; k++) begin
                chk("lone_cls", 32'(pop_cls[k]), 32'd2);
                chk("lone_rate", 32'(pop_c[k] - pop_c[0]), 32'(k));
                chk("lone_data", 32'(push_d[k]), 32'(12'h2A0 + k));
            end
        end
        chk("lone_cnt", class_cnt, 32'h04090404);

        // Backpressure after two pops of class 0.
        clear_logs();
        for (int k = 0; k < 4; k++) begin
            load(0, 12'(12'h600 + k));
            load(1, 12'(12'h610 + k));
        end
        t0 = cyc;
        step();
        step();
        dst_almost_full = 1'b1;
        #1;
        chk("bp_pop_now", 32'(src_pop), 32'd0);
        repeat (4) step();
        chk("bp_npop", 32'(pop_c.size()), 32'd2);
        chk("bp_npush", 32'(push_d.size()), 32'd2);
        if (push_d.size() == 2) begin
            chk("bp_d0", 32'(push_d[0]), 32'h600);
            chk("bp_d1", 32'(push_d[1]), 32'h601);
            chk("bp_c1", 32'(push_c[1]), 32'(t0 + 3));
        end
        dst_almost_full = 1'b0;
        for (int c = 0; c < 30 && push_d.size() < 8; c++) step();
        repeat (2) step();
        chk("bp_total_pop", 32'(pop_c.size()), 32'd8);
        chk("bp_total_push", 32'(push_d.size()), 32'd8);
        if (pop_c.size() == 8 && push_d.size() == 8) begin
            chk("bp_resume", 32'(pop_c[2]), 32'(t0 + 6));
            for (int k = 0; k < 8; k++) begin
                chk("bp_order", 32'(pop_cls[k]), 32'(exp_ord4[k]));
                chk("bp_data", 32'(push_d[k]), 32'(exp_dat4[k]));
            end
        end
        chk("bp_cnt", class_cnt, 32'h04090808);

        // Reset the cycle after a pop: the word is dropped.
        clear_logs();
        load(2, 12'h2B0);
        step();
        chk("rmf_gvalid", 32'(grant_valid), 32'd1);
        chk("rmf_gid", 32'(grant_id), 32'd2);
        reset = 1'b1;
        step();
        chk("rmf_push", 32'(dst_push), 32'd0);
        chk("rmf_data", 32'(dst_data), 32'd0);
        chk("rmf_gvalid0", 32'(grant_valid), 32'd0);
        chk("rmf_gid0", 32'(grant_id), 32'd0);
        chk("rmf_cnt", class_cnt, 32'd0);
        reset = 1'b0;
        repeat (3) step();
        chk("rmf_npop", 32'(pop_c.size()), 32'd1);
        chk("rmf_npush", 32'(push_d.size()), 32'd0);
        clear_logs();
        load(3, 12'h3C0);
        load(0, 12'h0C0);
        for (int c = 0; c < 20 && push_d.size() < 2; c++) step();
        chk("rmf_post_npush", 32'(push_d.size()), 32'd2);
        if (pop_cls.size() == 2 && push_d.size() == 2) begin
            chk("rmf_first_cls", 32'(pop_cls[0]), 32'd0);
            chk("rmf_second_cls", 32'(pop_cls[1]), 32'd3);
            chk("rmf_d0", 32'(push_d[0]), 32'h0C0);
            chk("rmf_d1", 32'(push_d[1]), 32'h3C0);
        end
        chk("rmf_post_cnt", class_cnt, 32'h01000001);

        // Counter wrap: 257 words from class 1 after a fresh reset.
        reset = 1'b1;
        step();
        reset = 1'b0;
        clear_logs();
        enable = 1'b0;
        for (int k = 0; k < 257; k++) load(1, 12'(k));
        step();
        chk("en_off_nopop", 32'(pop_c.size()), 32'd0);
        enable = 1'b1;
        for (int c = 0; c < 400 && push_d.size() < 257; c++) step();
        repeat (3) step();
        chk("wrap_npop", 32'(pop_c.size()), 32'd257);
        chk("wrap_npush", 32'(push_d.size()), 32'd257);
        if (pop_c.size() == 257 && push_d.size() == 257) begin
            chk("wrap_rate", 32'(pop_c[256] - pop_c[0]), 32'd256);
            chk("wrap_last", 32'(push_d[256]), 32'h100);
        end
        chk("wrap_cnt", class_cnt, 32'h00000100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
